inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Download controller and port arbiter for the instruction memory. Owns the single address/write port of the instruction RAM:
- Normally passes the core's fetch address straight through.
- On a download request, stalls the core and accepts a byte stream from a host downloader (JTAG/UART bridge).
- Packs bytes little-endian into 32-bit words and writes them to consecutive word addresses from 0.
- Sits between the core fetch path, the downloader and the instruction RAM.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the instruction RAM (depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_addr  in  ADDR_W  core fetch word address (pc[ADDR_W+1:2])
- core_stall  out  1  high while a download owns the RAM
- dl_start  in  1  single-cycle request to begin a download
- dl_len  in  ADDR_W+1  word count, sampled with dl_start
- dl_abort  in  1  cancel an in-progress download
- dl_valid  in  1  byte available
- dl_byte  in  8  download byte
- dl_ready  out  1  loader accepts dl_byte this cycle
- dl_busy  out  1  state != IDLE
- dl_done  out  1  single-cycle pulse when all dl_len words are written
- ram_addr  out  ADDR_W  to RAM address
- ram_wren  out  1  to RAM write enable
- ram_wrdata  out  32  to RAM write data

## Operation
- States: IDLE, LOAD, WRITE, DONE. Registers:
  - word_cnt (ADDR_W+1)
  - byte_cnt (2)
  - len_q (ADDR_W+1)
  - word_q (32)
- IDLE:
  - ram_addr = core_addr (combinational); ram_wren = 0; core_stall = 0; dl_ready = 0.
  - dl_start: capture len_q = min(dl_len, 2^ADDR_W); clear word_cnt and byte_cnt.
  - If len_q == 0, go to DONE; otherwise go to LOAD.
- LOAD:
  - dl_ready = 1. On dl_valid, byte goes to word_q[8*byte_cnt +: 8] (first byte → [7:0]) and byte_cnt increments.
  - When the 4th byte is accepted (byte_cnt == 3), go to WRITE.
- WRITE:
  - ram_wren = 1; ram_addr = word_cnt[ADDR_W-1:0]; ram_wrdata = word_q; dl_ready = 0.
  - Next: word_cnt++. If word_cnt+1 == len_q, go to DONE; else go to LOAD.
- DONE: dl_done = 1 for this one cycle; next state is IDLE.
- Outside IDLE:
  - core_stall = 1.
  - ram_addr = word_cnt[ADDR_W-1:0], except during WRITE, where it is defined above.
  - RAM read data presented to the core is don't-care.
- dl_start is ignored outside IDLE.
- dl_abort, in any non-IDLE state, sends the next state to IDLE with no dl_done:
  - A partially assembled word is discarded.
  - A write already in WRITE that cycle still occurs (ram_wren is a state decode).
  - abort takes priority over all other transitions.
- ram_wrdata = word_q at all times; it is only meaningful while ram_wren = 1.

## Timing
- Reset: state IDLE; word_cnt, byte_cnt, len_q and word_q = 0.
- Output values in reset:
  - ram_addr = core_addr; ram_wrdata = 0.
  - ram_wren, core_stall, dl_ready, dl_busy and dl_done = 0.
- core_stall, dl_busy, dl_ready, ram_wren and dl_done are pure decodes of the registered state. ram_addr has the one combinational path core_addr → ram_addr in IDLE.
- dl_start sampled high at edge T:
  - core_stall rises at T+1.
  - With dl_valid held high, bytes are accepted at T+1..T+4, and WRITE for word 0 is at T+5.
- Throughput: minimum 5 cycles per word. N words back-to-back put DONE at cycle T+5N+1 and IDLE (stall low) at T+5N+2.
- dl_len = 0: DONE at T+1, IDLE at T+2, no writes.
- dl_valid gaps in LOAD stretch the sequence with no other effect. byte_cnt is held, so byte order is preserved.
- The core must not rely on fetched data until the cycle after core_stall falls (synchronous RAM read latency 1).

## Test plan
- Reset mid-download: assert rst_n = 0 during LOAD after 2 bytes → all outputs at reset values immediately; after release, ram_addr follows core_addr and no write is issued.
- Single word: dl_start with dl_len = 1, bytes 0x13,0x00,0x00,0x00 back-to-back → one ram_wren pulse at addr 0, data 0x00000013, dl_done at T+6, core_stall low at T+7.
- Three words with random dl_valid gaps: bytes 0x00..0x0B → writes 0x03020100@0, 0x07060504@1, 0x0B0A0908@2 in order, exactly 3 wren pulses, dl_ready never high in WRITE.
- Full depth and saturation: dl_len = 2^ADDR_W + 5 → exactly 2^ADDR_W writes, last at addr 2^ADDR_W−1, then dl_done.
- Abort: dl_abort after word 0 written and 2 bytes of word 1 → return to IDLE next cycle, no dl_done, no second write. A following dl_start restarts at addr 0.
- Pass-through and edge cases:
  - In IDLE, a sweep of core_addr gives ram_addr equal in the same cycle with wren = 0.
  - dl_start while busy is ignored.
  - dl_len = 0 gives only a dl_done pulse at T+1.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction-RAM port owner: passes core fetch addresses through, or stalls the core while a
// host byte stream is packed little-endian into words and written from address 0 upward.
module inst_mem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_stall,
   input  logic              dl_start,
   input  logic [ADDR_W:0]   dl_len,
   input  logic              dl_abort,
   input  logic              dl_valid,
   input  logic [7:0]        dl_byte,
   output logic              dl_ready,
   output logic              dl_busy,
   output logic              dl_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [31:0]       ram_wrdata
);

   typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

   localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

   state_e          state_q, state_d;
   logic [ADDR_W:0] word_cnt_q, word_cnt_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [ADDR_W:0] len_q, len_d;
   logic [31:0]     word_q, word_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         len_q      <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         word_q     <= word_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      word_d     = word_q;
      unique case (state_q)
         StIdle: begin
            if (dl_start) begin
               len_d      = (dl_len > MaxLen) ? MaxLen : dl_len;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               state_d    = (dl_len == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            if (dl_valid) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = dl_byte;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = StWrite;
            end
         end
         StWrite: begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = (word_cnt_d == len_q) ? StDone : StLoad;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort wins over every other transition; the partial word is simply left behind.
      if (dl_abort && (state_q != StIdle)) state_d = StIdle;
   end

   assign core_stall = (state_q != StIdle);
   assign dl_busy    = (state_q != StIdle);
   assign dl_ready   = (state_q == StLoad);
   assign ram_wren   = (state_q == StWrite);
   assign dl_done    = (state_q == StDone);
   assign ram_wrdata = word_q;
   assign ram_addr   = (state_q == StIdle) ? core_addr : word_cnt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a write scoreboard built from the bytes sent, per-cycle protocol
// checks, and directed timing/count expectations.
module tb_inst_mem_loader;

   localparam int unsigned AW    = 10;
   localparam int unsigned Depth = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic          core_stall;
   logic          dl_start = 1'b0;
   logic [AW:0]   dl_len = '0;
   logic          dl_abort = 1'b0;
   logic          dl_valid = 1'b0;
   logic [7:0]    dl_byte = '0;
   logic          dl_ready, dl_busy, dl_done;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [31:0]   ram_wrdata;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int wr_count = 0;
   int done_count = 0;
   int done_cyc = -1;
   logic [AW-1:0] last_addr = '0;
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic [31:0]   wr_log[$];

   inst_mem_loader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_addr  (core_addr),
      .core_stall (core_stall),
      .dl_start   (dl_start),
      .dl_len     (dl_len),
      .dl_abort   (dl_abort),
      .dl_valid   (dl_valid),
      .dl_byte    (dl_byte),
      .dl_ready   (dl_ready),
      .dl_busy    (dl_busy),
      .dl_done    (dl_done),
      .ram_addr   (ram_addr),
      .ram_wren   (ram_wren),
      .ram_wrdata (ram_wrdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Continuous address sweep so pass-through is exercised on every idle cycle.
   always @(negedge clk) core_addr <= core_addr + 10'd37;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [7:0] bval(int pat, int k);
      logic [31:0] kk;
      kk = 32'(k);
      case (pat)
         0:       return kk[7:0];
         1:       return (k == 0) ? 8'h13 : 8'h00;
         default: return 8'(k * 7 + 1);
      endcase
   endfunction

   // Per-cycle compare against the scoreboard and the protocol rules.
   initial forever begin
      @(negedge clk);
      #1;
      check("busy_eq_stall", dl_busy, core_stall);
      if (!core_stall) begin
         check("pass_addr", ram_addr, core_addr);
         check("idle_wren", ram_wren, 0);
         check("idle_ready", dl_ready, 0);
      end
      if (ram_wren) begin
         check("ready_in_write", dl_ready, 0);
         wr_count++;
         last_addr = ram_addr;
         wr_log.push_back(ram_wrdata);
         if (exp_addr.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: got write addr 0x%0h data 0x%0h, want none",
                     ram_addr, ram_wrdata);
         end else begin
            check("wr_addr", ram_addr, exp_addr.pop_front());
            check("wr_data", ram_wrdata, exp_data.pop_front());
         end
      end
      if (dl_done) begin
         done_count++;
         done_cyc = cyc;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; t is the index of the cycle closed by the edge that samples dl_start.
   task automatic start(input int len, output int t);
      t = cyc;
      dl_start = 1'b1;
      dl_len = (AW + 1)'(len);
      @(negedge clk);
      dl_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int g = 0;
      repeat (gap) begin
         dl_valid = 1'b0;
         @(negedge clk);
      end
      dl_valid = 1'b1;
      dl_byte = b;
      while (!dl_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!dl_ready) begin
         compared++;
         mismatched++;
         $display("FAIL byte_accept: got dl_ready=0 for 100 cycles, want 1");
      end
      @(negedge clk);
      dl_valid = 1'b0;
   endtask

   task automatic load(input int base, input int n, input int pat, input int maxgap);
      logic [31:0] w;
      logic [7:0]  b;
      for (int i = base; i < base + n; i++) begin
         w = '0;
         for (int j = 0; j < 4; j++) begin
            b = bval(pat, i * 4 + j);
            w = w | (32'(b) << (8 * j));
            send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
         end
         exp_addr.push_back(AW'(i));
         exp_data.push_back(w);
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while (core_stall && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("idle_reached", core_stall, 0);
   endtask

   task automatic clear_stats();
      wr_count = 0;
      done_count = 0;
      done_cyc = -1;
      wr_log.delete();
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_stall"}, core_stall, 0);
      check({tag, "_busy"}, dl_busy, 0);
      check({tag, "_ready"}, dl_ready, 0);
      check({tag, "_wren"}, ram_wren, 0);
      check({tag, "_done"}, dl_done, 0);
      check({tag, "_wrdata"}, ram_wrdata, 0);
      check({tag, "_addr"}, ram_addr, core_addr);
   endtask

   initial begin
      int t;
      @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single word: done one cycle after the write, stall low the cycle after that.
      clear_stats();
      start(1, t);
      check("stall_rise", core_stall, 1);
      load(0, 1, 1, 0);
      wait_idle();
      check("single_stall_fall", cyc, t + 7);
      check("single_done_cyc", done_cyc, t + 6);
      check("single_done_cnt", done_count, 1);
      check("single_wr_cnt", wr_count, 1);
      check("single_wr_addr", last_addr, 0);
      if (wr_log.size() > 0) check("single_wr_data", wr_log[0], 32'h0000_0013);

      // Three words with random valid gaps.
      clear_stats();
      start(3, t);
      load(0, 3, 0, 3);
      wait_idle();
      check("three_wr_cnt", wr_count, 3);
      check("three_done_cnt", done_count, 1);
      if (wr_log.size() == 3) begin
         check("three_w0", wr_log[0], 32'h0302_0100);
         check("three_w1", wr_log[1], 32'h0706_0504);
         check("three_w2", wr_log[2], 32'h0B0A_0908);
      end

      // dl_start while busy is ignored; back-to-back timing of two words.
      clear_stats();
      start(2, t);
      load(0, 1, 2, 0);
      dl_start = 1'b1;
      dl_len = '0;
      load(1, 1, 2, 0);
      dl_start = 1'b0;
      wait_idle();
      check("busy_start_done_cyc", done_cyc, t + 11);
      check("busy_start_done_cnt", done_count, 1);
      check("busy_start_wr_cnt", wr_count, 2);

      // Zero length: only a done pulse.
      clear_stats();
      start(0, t);
      wait_idle();
      check("len0_done_cyc", done_cyc, t + 1);
      check("len0_stall_fall", cyc, t + 2);
      check("len0_wr_cnt", wr_count, 0);
      check("len0_done_cnt", done_count, 1);

      // Oversized length saturates to the full RAM depth.
      clear_stats();
      start(Depth + 5, t);
      load(0, Depth, 2, 0);
      wait_idle();
      check("full_wr_cnt", wr_count, Depth);
      check("full_last_addr", last_addr, Depth - 1);
      check("full_done_cnt", done_count, 1);
      check("full_done_cyc", done_cyc, t + 5 * Depth + 1);

      // Abort after word 0 and two bytes of word 1, then restart from address 0.
      clear_stats();
      start(4, t);
      load(0, 1, 0, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      dl_abort = 1'b1;
      @(negedge clk);
      dl_abort = 1'b0;
      check("abort_idle", core_stall, 0);
      repeat (6) @(negedge clk);
      check("abort_done_cnt", done_count, 0);
      check("abort_wr_cnt", wr_count, 1);
      start(1, t);
      load(0, 1, 2, 0);
      wait_idle();
      check("restart_wr_cnt", wr_count, 2);
      check("restart_addr", last_addr, 0);
      check("restart_done_cnt", done_count, 1);

      // Reset during LOAD after two bytes.
      clear_stats();
      start(3, t);
      send_byte(bval(2, 0), 0);
      send_byte(bval(2, 1), 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_wr_cnt", wr_count, 0);
      check("midrst_done_cnt", done_count, 0);
      check("midrst_idle", core_stall, 0);

      check("scoreboard_empty", exp_addr.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
